// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioning logic.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    L2H  = 2'b01,
    HIGH = 2'b11,
    H2L  = 2'b10
  } btn_state_e;

  localparam int DEB_STABLE_CYCLES = 1_000_000;
  localparam int DEB_LONG_CYCLES   = 50_000_000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT and emits a registered one-cycle pulse
// on the edge where it reaches LIMIT.
module sat_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         hit_pulse
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;
  logic         hit_q, hit_d;

  // A clear on the same edge that would reach LIMIT still reports the hit.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (en && (cnt_q < LIM)) begin
      cnt_d = cnt_q + 1'b1;
      hit_d = (cnt_q == LIM - 1'b1);
    end
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign cnt       = cnt_q;
  assign hit_pulse = hit_q;

endmodule

// File: rtl/btn_debounce_edge.sv
// Debounces a synchronized button level and derives edge pulses, a one-shot
// long-press pulse and a wrapping press counter.
module btn_debounce_edge
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEB_LONG_CYCLES,
  parameter int PRESS_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din,
  output logic                   level,
  output logic                   rise,
  output logic                   fall,
  output logic                   long_press,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  btn_state_e             state_q, state_d;
  logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   hold_clr, hold_en;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   long_hit;

  always_comb begin
    state_d       = state_q;
    stab_cnt_d    = stab_cnt_q;
    level_d       = level_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    press_count_d = press_count_q;
    hold_clr      = 1'b0;
    unique case (state_q)
      LOW: begin
        if (din) begin
          state_d    = L2H;
          stab_cnt_d = '0;
        end
      end
      L2H: begin
        if (!din) begin
          state_d    = LOW;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d       = HIGH;
          stab_cnt_d    = '0;
          level_d       = 1'b1;
          rise_d        = 1'b1;
          press_count_d = press_count_q + 1'b1;
          hold_clr      = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (!din) begin
          state_d    = H2L;
          stab_cnt_d = '0;
        end
      end
      H2L: begin
        // A bounce back to 1 keeps the press alive, so hold time keeps accruing.
        if (din) begin
          state_d    = HIGH;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d    = LOW;
          stab_cnt_d = '0;
          level_d    = 1'b0;
          fall_d     = 1'b1;
          hold_clr   = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = LOW;
        stab_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOW;
      stab_cnt_q    <= '0;
      level_q       <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stab_cnt_q    <= stab_cnt_d;
      level_q       <= level_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      press_count_q <= press_count_d;
    end
  end

  assign hold_en = (state_q == HIGH) || (state_q == H2L);

  sat_counter #(
    .W     (HOLD_W),
    .LIMIT (LONG_CYCLES)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (hold_clr),
    .en        (hold_en),
    .cnt       (hold_cnt),
    .hit_pulse (long_hit)
  );

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign long_press  = long_hit;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// Self-checking bench for btn_debounce_edge with short debounce/long-press timing.
module tb_btn_debounce_edge;

  localparam int S  = 4;
  localparam int L  = 20;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          level, rise, fall, long_press;
  logic [CW-1:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  btn_debounce_edge #(
    .STABLE_CYCLES (S),
    .LONG_CYCLES   (L),
    .PRESS_CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .long_press  (long_press),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       din;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];

  // Packed expectation: {level, rise, fall, long_press, press_count}
  function automatic logic [7:0] ex(input logic l, input logic r, input logic f,
                                    input logic lp, input int c);
    return {l, r, f, lp, 4'(c)};
  endfunction

  function automatic logic [7:0] actual();
    return {level, rise, fall, long_press, press_count};
  endfunction

  task automatic compare(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got lvl=%b rise=%b fall=%b long=%b cnt=%0d, want lvl=%b rise=%b fall=%b long=%b cnt=%0d",
               name, got[7], got[6], got[5], got[4], got[3:0],
               want[7], want[6], want[5], want[4], want[3:0]);
    end
  endtask

  // Called at a negedge: drive, push expectation, let one posedge pass, check at next negedge.
  task automatic step(input logic r, input logic d, input logic [7:0] e, input string name);
    rst_n = r;
    din   = d;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare(name, actual(), sb.pop_front());
  endtask

  task automatic add(input logic r, input logic d, input logic [7:0] e);
    vec_t v;
    v.rst_n = r;
    v.din   = d;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int longs;

    // Reset with din=1, then fresh press accepted on the 5th edge.
    add(0, 1, ex(0,0,0,0,0)); add(0, 1, ex(0,0,0,0,0));
    for (int i = 0; i < 4; i++) add(1, 1, ex(0,0,0,0,0));
    add(1, 1, ex(1,1,0,0,1)); add(1, 1, ex(1,0,0,0,1));
    // Glitch rejection: 3 highs, 1 low, then 5 highs.
    add(0, 0, ex(0,0,0,0,0));
    for (int i = 0; i < 3; i++) add(1, 1, ex(0,0,0,0,0));
    add(1, 0, ex(0,0,0,0,0));
    for (int i = 0; i < 4; i++) add(1, 1, ex(0,0,0,0,0));
    add(1, 1, ex(1,1,0,0,1));
    // Release bounce: 0,0,1 then five zeros.
    add(1, 0, ex(1,0,0,0,1)); add(1, 0, ex(1,0,0,0,1)); add(1, 1, ex(1,0,0,0,1));
    for (int i = 0; i < 4; i++) add(1, 0, ex(1,0,0,0,1));
    add(1, 0, ex(0,0,1,0,1)); add(1, 0, ex(0,0,0,0,1));

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i].rst_n, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

    // Long press: long_press exactly once, 20 edges after the rise edge.
    for (int i = 1; i <= 4; i++) step(1, 1, ex(0,0,0,0,1), "long_pre");
    step(1, 1, ex(1,1,0,0,2), "long_rise");
    longs = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1, 1, ex(1,0,0,(k == L),2), $sformatf("long_hold%0d", k));
      if (long_press) longs++;
    end
    for (int j = 1; j <= 4; j++) step(1, 0, ex(1,0,0,0,2), "long_rel");
    step(1, 0, ex(0,0,1,0,2), "long_fall");
    for (int j = 1; j <= 3; j++) begin
      step(1, 0, ex(0,0,0,0,2), "long_after");
      if (long_press) longs++;
    end
    compare("long_once", 8'(longs), 8'd1);

    // Reset while in L2H with stab_cnt=2.
    for (int i = 1; i <= 3; i++) step(1, 1, ex(0,0,0,0,2), "mid_l2h");
    rst_n = 1'b0;
    #1;
    compare("async_rst", actual(), ex(0,0,0,0,0));
    step(0, 1, ex(0,0,0,0,0), "mid_rst");
    step(0, 1, ex(0,0,0,0,0), "mid_rst");
    for (int i = 1; i <= 4; i++) step(1, 1, ex(0,0,0,0,0), "mid_fresh");
    step(1, 1, ex(1,1,0,0,1), "mid_rise");
    for (int j = 1; j <= 4; j++) step(1, 0, ex(1,0,0,0,1), "mid_rel");
    step(1, 0, ex(0,0,1,0,1), "mid_fall");

    // 16 clean presses: counter wraps to 0 on the 16th rise.
    step(0, 0, ex(0,0,0,0,0), "wrap_rst");
    for (int p = 1; p <= 16; p++) begin
      for (int i = 1; i <= 4; i++) step(1, 1, ex(0,0,0,0,(p-1)%16), $sformatf("wrap%0d_hi", p));
      step(1, 1, ex(1,1,0,0,p%16), $sformatf("wrap%0d_rise", p));
      for (int i = 1; i <= 4; i++) step(1, 0, ex(1,0,0,0,p%16), $sformatf("wrap%0d_lo", p));
      step(1, 0, ex(0,0,1,0,p%16), $sformatf("wrap%0d_fall", p));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
